// File: rtl/se_lookup_arbiter_pkg.sv
// Shared definitions for the search-engine lookup arbiter: FSM state
// encoding, key/result widths, the latched key record and the
// round-robin pointer advance helper.
package se_arb_pkg;

  localparam int MAC_W  = 48;
  localparam int HASH_W = 12;
  localparam int RES_W  = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_REL  = 2'd2;

  typedef struct packed {
    logic [MAC_W-1:0]  dmac;
    logic [MAC_W-1:0]  smac;
    logic [HASH_W-1:0] hash;
  } se_key_t;

  // Pointer value that gives the requester after g first look next time.
  function automatic logic [2:0] rr_next(input logic [2:0] g, input int n);
    return 3'((int'(g) + 1) % n);
  endfunction

endpackage

// File: rtl/se_lookup_arbiter_if.sv
// Engine-side bus of the lookup arbiter: key and level request toward
// the hash search engine, ack/nak pulses and result back from it.
interface se_lookup_arbiter_if;
  import se_arb_pkg::*;

  logic              se_req;
  logic [MAC_W-1:0]  se_dmac;
  logic [MAC_W-1:0]  se_smac;
  logic [HASH_W-1:0] se_hash;
  logic              se_ack;
  logic              se_nak;
  logic [RES_W-1:0]  se_result;

  // Arbiter side: drives the request and key.
  modport master (
    output se_req, se_dmac, se_smac, se_hash,
    input  se_ack, se_nak, se_result
  );

  // Search engine side.
  modport slave (
    input  se_req, se_dmac, se_smac, se_hash,
    output se_ack, se_nak, se_result
  );

endinterface

// File: rtl/se_lookup_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request bit at or above
// ptr, wrapping modulo NREQ.
module se_rr_pick #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [2:0]      ptr,
  output logic            vld,
  output logic [2:0]      idx
);

  // Scan NREQ positions starting at ptr; the first hit wins.
  always_comb begin
    vld = 1'b0;
    idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!vld && req[(int'(ptr) + k) % NREQ]) begin
        vld = 1'b1;
        idx = 3'((int'(ptr) + k) % NREQ);
      end
    end
  end

endmodule

// File: rtl/se_lookup_arbiter.sv
// Shares one MAC/hash search engine between NREQ frame-process
// requesters. Round-robin grant, a single lookup outstanding, key
// registered toward the engine, ack/nak/result routed back to the
// granted requester only.
// Optional: define SE_ARB_TIMEOUT_EN to nak a lookup the engine leaves
// unanswered for TIMEOUT_CYC cycles and raise the sticky err_timeout.
module se_lookup_arbiter
  import se_arb_pkg::*;
#(
  parameter int NREQ        = 2,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NREQ-1:0]      rq_req,
  input  logic [NREQ*MAC_W-1:0]  rq_dmac,
  input  logic [NREQ*MAC_W-1:0]  rq_smac,
  input  logic [NREQ*HASH_W-1:0] rq_hash,
  output logic [NREQ-1:0]      rq_ack,
  output logic [NREQ-1:0]      rq_nak,
  output logic [RES_W-1:0]     rq_result,
  se_lookup_arbiter_if.master  se,
  output logic [2:0]           grant_id,
  output logic                 busy,
  output logic                 err_timeout
);

  logic [1:0]       state;
  logic [2:0]       ptr;
  logic [2:0]       grant_q;
  se_key_t          key_q;
  se_key_t          pick_key;
  logic             se_req_q;
  logic [NREQ-1:0]  ack_q;
  logic [NREQ-1:0]  nak_q;
  logic [NREQ-1:0]  g_onehot;
  logic [RES_W-1:0] result_q;
  logic             pick_vld;
  logic [2:0]       pick_idx;

`ifdef SE_ARB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
  logic [CNT_W-1:0] cnt;
  logic             err_q;
`endif

  se_rr_pick #(.NREQ(NREQ)) u_pick (
    .req (rq_req),
    .ptr (ptr),
    .vld (pick_vld),
    .idx (pick_idx)
  );

  // Key of the requester the picker selects, and one-hot of the holder.
  always_comb begin
    pick_key.dmac = rq_dmac[MAC_W*int'(pick_idx) +: MAC_W];
    pick_key.smac = rq_smac[MAC_W*int'(pick_idx) +: MAC_W];
    pick_key.hash = rq_hash[HASH_W*int'(pick_idx) +: HASH_W];
    g_onehot      = NREQ'(1) << grant_q;
  end

  // Grant/wait/release FSM; ack/nak are single-cycle pulses by default-clear.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= ST_IDLE;
      ptr      <= '0;
      grant_q  <= '0;
      key_q    <= '0;
      se_req_q <= 1'b0;
      ack_q    <= '0;
      nak_q    <= '0;
      result_q <= '0;
`ifdef SE_ARB_TIMEOUT_EN
      cnt      <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      ack_q <= '0;
      nak_q <= '0;
      case (state)
        ST_IDLE: begin
          if (pick_vld) begin
            grant_q  <= pick_idx;
            key_q    <= pick_key;
            se_req_q <= 1'b1;
            state    <= ST_WAIT;
`ifdef SE_ARB_TIMEOUT_EN
            cnt      <= '0;
`endif
          end
        end
        ST_WAIT: begin
          // A nak, even alongside an ack, ends the lookup without a result.
          if (se.se_nak) begin
            se_req_q <= 1'b0;
            nak_q    <= g_onehot;
            state    <= ST_REL;
          end else if (se.se_ack) begin
            se_req_q <= 1'b0;
            ack_q    <= g_onehot;
            result_q <= se.se_result;
            state    <= ST_REL;
          end
`ifdef SE_ARB_TIMEOUT_EN
          else if (cnt == CNT_W'(TIMEOUT_CYC)) begin
            se_req_q <= 1'b0;
            nak_q    <= g_onehot;
            err_q    <= 1'b1;
            state    <= ST_REL;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        ST_REL: begin
          // Hold off until the served requester drops its level request.
          if ((rq_req & g_onehot) == '0) begin
            ptr   <= rr_next(grant_q, NREQ);
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign se.se_req   = se_req_q;
  assign se.se_dmac  = key_q.dmac;
  assign se.se_smac  = key_q.smac;
  assign se.se_hash  = key_q.hash;
  assign rq_ack      = ack_q;
  assign rq_nak      = nak_q;
  assign rq_result   = result_q;
  assign grant_id    = grant_q;
  assign busy        = (state != ST_IDLE);
`ifdef SE_ARB_TIMEOUT_EN
  assign err_timeout = err_q;
`else
  assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_se_lookup_arbiter.sv
// Self-checking bench for se_lookup_arbiter (NREQ=2, TIMEOUT_CYC=16).
// Expected responses are pushed to a scoreboard queue when the engine
// pulse is driven and popped when the requester-side pulse appears.
module tb_se_lookup_arbiter;

  localparam int NREQ = 2;

  typedef struct {
    logic [NREQ-1:0] ack;
    logic [NREQ-1:0] nak;
    logic [15:0]     res;
  } exp_t;

  logic                clk = 1'b0;
  logic                rstn = 1'b0;
  logic [NREQ-1:0]     rq_req = '0;
  logic [NREQ*48-1:0]  rq_dmac = '0;
  logic [NREQ*48-1:0]  rq_smac = '0;
  logic [NREQ*12-1:0]  rq_hash = '0;
  logic [NREQ-1:0]     rq_ack;
  logic [NREQ-1:0]     rq_nak;
  logic [15:0]         rq_result;
  logic [2:0]          grant_id;
  logic                busy;
  logic                err_timeout;

  se_lookup_arbiter_if sif();

  se_lookup_arbiter #(.NREQ(NREQ), .TIMEOUT_CYC(16)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .rq_req      (rq_req),
    .rq_dmac     (rq_dmac),
    .rq_smac     (rq_smac),
    .rq_hash     (rq_hash),
    .rq_ack      (rq_ack),
    .rq_nak      (rq_nak),
    .rq_result   (rq_result),
    .se          (sif),
    .grant_id    (grant_id),
    .busy        (busy),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  exp_t        sb[$];
  logic [15:0] m_res = '0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rstn = 1'b0;
    rq_req = '0;
    sif.se_ack = 1'b0;
    sif.se_nak = 1'b0;
    sif.se_result = '0;
    sb.delete();
    m_res = '0;
    tick;
    tick;
    rstn = 1'b1;
    tick;
  endtask

  task automatic wait_se_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (sif.se_req === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick;
    end
  endtask

  // Drive one engine response cycle and record what requester g should see.
  task automatic engine_pulse(input logic a, input logic n, input logic [15:0] r, input int g);
    exp_t e;
    e.ack = '0;
    e.nak = '0;
    e.res = m_res;
    if (n) begin
      e.nak[g] = 1'b1;
    end else if (a) begin
      e.ack[g] = 1'b1;
      m_res = r;
      e.res = r;
    end
    sb.push_back(e);
    sif.se_ack = a;
    sif.se_nak = n;
    sif.se_result = r;
    tick;
    sif.se_ack = 1'b0;
    sif.se_nak = 1'b0;
  endtask

  task automatic set_keys;
    rq_dmac[47:0]  = 48'h0011_2233_4455;
    rq_smac[47:0]  = 48'h0A0B_0C0D_0E0F;
    rq_hash[11:0]  = 12'h5A3;
    rq_dmac[95:48] = 48'hB1B1_0000_0001;
    rq_smac[95:48] = 48'hC2C2_0000_0002;
    rq_hash[23:12] = 12'h222;
  endtask

  task automatic test_reset;
    sif.se_ack = 1'b0;
    sif.se_nak = 1'b0;
    sif.se_result = '0;
    rstn = 1'b0;
    #3;
    tests++;
    if ({rq_ack, rq_nak, rq_result, grant_id, busy, err_timeout} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got ack=%b nak=%b res=%h gid=%0d busy=%b err=%b, expected all 0",
               rq_ack, rq_nak, rq_result, grant_id, busy, err_timeout);
    end
    tests++;
    if ({sif.se_req, sif.se_dmac, sif.se_smac, sif.se_hash} !== '0) begin
      fails++;
      $display("FAIL reset_engine_side: got se_req=%b dmac=%h hash=%h, expected 0",
               sif.se_req, sif.se_dmac, sif.se_hash);
    end
    tick;
    rstn = 1'b1;
    tick;
  endtask

  task automatic test_single;
    exp_t e;
    do_reset;
    set_keys;
    rq_req = 2'b01;
    tick;
    tests++;
    if ({sif.se_req, sif.se_dmac, sif.se_smac, sif.se_hash, grant_id, busy} !==
        {1'b1, 48'h0011_2233_4455, 48'h0A0B_0C0D_0E0F, 12'h5A3, 3'd0, 1'b1}) begin
      fails++;
      $display("FAIL single_grant: got se_req=%b dmac=%h smac=%h hash=%h gid=%0d busy=%b, expected 1 001122334455 0a0b0c0d0e0f 5a3 0 1",
               sif.se_req, sif.se_dmac, sif.se_smac, sif.se_hash, grant_id, busy);
    end
    tick;
    tick;
    tests++;
    if ({sif.se_req, sif.se_dmac, sif.se_hash} !== {1'b1, 48'h0011_2233_4455, 12'h5A3}) begin
      fails++;
      $display("FAIL single_hold: got se_req=%b dmac=%h hash=%h, expected 1 001122334455 5a3",
               sif.se_req, sif.se_dmac, sif.se_hash);
    end
    engine_pulse(1'b1, 1'b0, 16'h0004, 0);
    e = sb.pop_front();
    tests++;
    if ({rq_ack, rq_nak, rq_result} !== {e.ack, e.nak, e.res}) begin
      fails++;
      $display("FAIL single_resp: got ack=%b nak=%b res=%h, expected ack=%b nak=%b res=%h",
               rq_ack, rq_nak, rq_result, e.ack, e.nak, e.res);
    end
    rq_req = 2'b00;
    tick;
    tests++;
    if ({rq_ack, rq_nak, sif.se_req} !== '0) begin
      fails++;
      $display("FAIL single_pulse_width: got ack=%b nak=%b se_req=%b, expected 0",
               rq_ack, rq_nak, sif.se_req);
    end
    tests++;
    if (busy !== 1'b0 || rq_result !== 16'h0004) begin
      fails++;
      $display("FAIL single_release: got busy=%b res=%h, expected busy=0 res=0004", busy, rq_result);
    end
  endtask

  task automatic test_contention;
    exp_t e;
    bit   ok;
    int   prev;
    int   exp_g;
    do_reset;
    set_keys;
    rq_hash[11:0] = 12'h111;
    rq_req = 2'b11;
    prev = -1;
    for (int n = 0; n < 4; n++) begin
      exp_g = n % 2;
      wait_se_req(ok);
      tests++;
      if (!ok) begin
        fails++;
        $display("FAIL contention_se_req_timeout: got no se_req, expected grant %0d", exp_g);
      end
      tests++;
      if (grant_id !== 3'(exp_g) || sif.se_hash !== ((exp_g == 1) ? 12'h222 : 12'h111)) begin
        fails++;
        $display("FAIL contention_order: got gid=%0d hash=%h, expected gid=%0d", grant_id, sif.se_hash, exp_g);
      end
      tests++;
      if (int'(grant_id) == prev) begin
        fails++;
        $display("FAIL contention_repeat: got gid=%0d twice, expected alternation", grant_id);
      end
      prev = int'(grant_id);
      tick;
      engine_pulse(1'b1, 1'b0, 16'h1000 + 16'(n), exp_g);
      e = sb.pop_front();
      tests++;
      if ({rq_ack, rq_nak, rq_result} !== {e.ack, e.nak, e.res}) begin
        fails++;
        $display("FAIL contention_resp: got ack=%b nak=%b res=%h, expected ack=%b nak=%b res=%h",
                 rq_ack, rq_nak, rq_result, e.ack, e.nak, e.res);
      end
      rq_req[exp_g] = 1'b0;
      tick;
      rq_req[exp_g] = 1'b1;
    end
    rq_req = 2'b00;
    tick;
    tick;
  endtask

  task automatic test_nak;
    exp_t e;
    bit   ok;
    rq_req = 2'b10;
    wait_se_req(ok);
    tests++;
    if (!ok || grant_id !== 3'd1) begin
      fails++;
      $display("FAIL nak_grant: got ok=%b gid=%0d, expected gid=1", ok, grant_id);
    end
    tick;
    engine_pulse(1'b0, 1'b1, 16'hDEAD, 1);
    e = sb.pop_front();
    tests++;
    if ({rq_ack, rq_nak, rq_result} !== {e.ack, e.nak, e.res}) begin
      fails++;
      $display("FAIL nak_resp: got ack=%b nak=%b res=%h, expected ack=%b nak=%b res=%h",
               rq_ack, rq_nak, rq_result, e.ack, e.nak, e.res);
    end
    // Stray engine ack while releasing must be ignored.
    sif.se_ack = 1'b1;
    sif.se_result = 16'hBEEF;
    tick;
    sif.se_ack = 1'b0;
    tests++;
    if ({rq_ack, rq_nak, rq_result} !== {2'b00, 2'b00, m_res}) begin
      fails++;
      $display("FAIL nak_stray_ack: got ack=%b nak=%b res=%h, expected ack=00 nak=00 res=%h",
               rq_ack, rq_nak, rq_result, m_res);
    end
    tick;
    tick;
    tests++;
    if (busy !== 1'b1 || sif.se_req !== 1'b0) begin
      fails++;
      $display("FAIL nak_hold_rel: got busy=%b se_req=%b, expected busy=1 se_req=0", busy, sif.se_req);
    end
    rq_req = 2'b00;
    tick;
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL nak_idle: got busy=%b, expected 0", busy);
    end
  endtask

  task automatic test_both;
    exp_t e;
    bit   ok;
    rq_req = 2'b01;
    wait_se_req(ok);
    tick;
    engine_pulse(1'b1, 1'b1, 16'h7777, 0);
    e = sb.pop_front();
    tests++;
    if (!ok || {rq_ack, rq_nak, rq_result} !== {e.ack, e.nak, e.res}) begin
      fails++;
      $display("FAIL both_ack_nak: got ok=%b ack=%b nak=%b res=%h, expected ack=%b nak=%b res=%h",
               ok, rq_ack, rq_nak, rq_result, e.ack, e.nak, e.res);
    end
    rq_req = 2'b00;
    tick;
    tick;
  endtask

  task automatic test_timeout;
    exp_t e;
    bit   ok;
    int   n;
`ifdef SE_ARB_TIMEOUT_EN
    do_reset;
    rq_req = 2'b01;
    wait_se_req(ok);
    n = 0;
    while (rq_nak === 2'b00 && n < 40) begin
      tick;
      n++;
    end
    tests++;
    if (!ok || n != 17) begin
      fails++;
      $display("FAIL timeout_latency: got %0d cycles, expected 17", n);
    end
    tests++;
    if (rq_nak !== 2'b01 || err_timeout !== 1'b1 || rq_ack !== 2'b00) begin
      fails++;
      $display("FAIL timeout_flag: got nak=%b ack=%b err=%b, expected nak=01 ack=00 err=1",
               rq_nak, rq_ack, err_timeout);
    end
    rq_req = 2'b00;
    tick;
    tick;
    do_reset;
    rq_req = 2'b01;
    wait_se_req(ok);
    repeat (16) tick;
    engine_pulse(1'b1, 1'b0, 16'h00AB, 0);
    e = sb.pop_front();
    tests++;
    if ({rq_ack, rq_nak, rq_result, err_timeout} !== {e.ack, e.nak, e.res, 1'b0}) begin
      fails++;
      $display("FAIL timeout_ack_precedence: got ack=%b nak=%b res=%h err=%b, expected ack=%b nak=%b res=%h err=0",
               rq_ack, rq_nak, rq_result, err_timeout, e.ack, e.nak, e.res);
    end
`else
    do_reset;
    rq_req = 2'b01;
    wait_se_req(ok);
    repeat (40) tick;
    tests++;
    if (!ok || {sif.se_req, busy, err_timeout, rq_nak} !== {1'b1, 1'b1, 1'b0, 2'b00}) begin
      fails++;
      $display("FAIL wait_forever: got se_req=%b busy=%b err=%b nak=%b, expected 1 1 0 00",
               sif.se_req, busy, err_timeout, rq_nak);
    end
    engine_pulse(1'b1, 1'b0, 16'h00AB, 0);
    e = sb.pop_front();
    tests++;
    if ({rq_ack, rq_nak, rq_result} !== {e.ack, e.nak, e.res}) begin
      fails++;
      $display("FAIL late_ack: got ack=%b nak=%b res=%h, expected ack=%b nak=%b res=%h",
               rq_ack, rq_nak, rq_result, e.ack, e.nak, e.res);
    end
`endif
    rq_req = 2'b00;
    tick;
  endtask

  task automatic test_reset_wait;
    exp_t e;
    bit   ok;
    do_reset;
    rq_req = 2'b01;
    wait_se_req(ok);
    tick;
    #2;
    rstn = 1'b0;
    #1;
    tests++;
    if (!ok || {sif.se_req, busy, rq_ack, rq_nak, grant_id} !== '0) begin
      fails++;
      $display("FAIL reset_in_wait: got se_req=%b busy=%b ack=%b nak=%b gid=%0d, expected all 0",
               sif.se_req, busy, rq_ack, rq_nak, grant_id);
    end
    rq_req = 2'b00;
    sb.delete();
    m_res = '0;
    tick;
    rstn = 1'b1;
    rq_req = 2'b10;
    wait_se_req(ok);
    tests++;
    if (!ok || grant_id !== 3'd1 || sif.se_hash !== 12'h222) begin
      fails++;
      $display("FAIL reset_regrant: got ok=%b gid=%0d hash=%h, expected gid=1 hash=222",
               ok, grant_id, sif.se_hash);
    end
    tick;
    engine_pulse(1'b1, 1'b0, 16'h0C0C, 1);
    e = sb.pop_front();
    tests++;
    if ({rq_ack, rq_nak, rq_result} !== {e.ack, e.nak, e.res}) begin
      fails++;
      $display("FAIL reset_regrant_resp: got ack=%b nak=%b res=%h, expected ack=%b nak=%b res=%h",
               rq_ack, rq_nak, rq_result, e.ack, e.nak, e.res);
    end
    rq_req = 2'b00;
    tick;
  endtask

  initial begin
    test_reset;
    test_single;
    test_contention;
    test_nak;
    test_both;
    test_timeout;
    test_reset_wait;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
